// File: rtl/game_pkg.sv
// Shared breakout definitions: game phase encoding and brick field geometry.
// Used by the sequencing controller, its bus interface and the brick store.
package game_pkg;

  localparam int BRICK_ROWS     = 7;
  localparam int BRICKS_PER_ROW = 8;
  localparam int NUM_BRICKS     = 56;
  localparam int BRICK_IDX_W    = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    CLEAR = 3'd3,
    MISS  = 3'd4,
    WIN   = 3'd5,
    OVER  = 3'd6
  } state_t;

endpackage

// File: rtl/brick_game_ctrl_if.sv
// Controller <-> brick store bus: brick map, one-at-a-time clear handshake
// and the field reload pulse.
interface brick_game_ctrl_if;
  import game_pkg::*;

  logic [NUM_BRICKS-1:0]  bricks;
  logic                   clear_valid;
  logic [BRICK_IDX_W-1:0] clear_index;
  logic                   clear_ready;
  logic                   reload;

  modport master (input bricks, clear_ready, output clear_valid, clear_index, reload);
  modport slave  (output bricks, clear_ready, input clear_valid, clear_index, reload);
endinterface

// File: rtl/brick_index_map.sv
// Ball position to brick index. Rows 1..7 hold bricks; each brick spans
// two ball columns. Index reads as 0 outside the brick area.
module brick_index_map
  import game_pkg::*;
(
  input  logic [3:0]             i_row,
  input  logic [3:0]             i_col,
  output logic [BRICK_IDX_W-1:0] o_index,
  output logic                   o_in_area
);

  logic [2:0] w_row_m1;
  logic       w_unused_col0;

  assign w_unused_col0 = i_col[0];
  assign o_in_area     = (i_row >= 4'd1) && (i_row <= 4'(BRICK_ROWS));
  assign w_row_m1      = i_row[2:0] - 3'd1;
  assign o_index       = o_in_area ? {w_row_m1, i_col[3:1]} : '0;

endmodule

// File: rtl/brick_game_ctrl.sv
// Breakout sequencing controller: game phase FSM, hit detection, brick-clear
// handshake, lives/bricks bookkeeping. BRICK_GAME_CTRL_AUTOSERVE_EN adds auto-serve.
module brick_game_ctrl
  import game_pkg::*;
#(
  parameter int INIT_LIVES  = 3,
  parameter int SERVE_TICKS = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_step_tick,
  input  logic [3:0]         i_ball_row,
  input  logic [3:0]         i_ball_col,
  input  logic               i_ball_miss,
  brick_game_ctrl_if.master  bus,
  output logic               o_serve,
  output logic               o_ball_run,
  output logic [1:0]         o_lives,
  output logic [5:0]         o_bricks_left,
  output logic [2:0]         o_state
);

  localparam logic [1:0] LIVES_INIT  = 2'(INIT_LIVES);
  localparam logic [5:0] BRICKS_INIT = 6'(NUM_BRICKS);

  if (INIT_LIVES < 1 || INIT_LIVES > 3 || SERVE_TICKS < 1) begin : g_bad_param
    $error("brick_game_ctrl: INIT_LIVES must be 1..3 and SERVE_TICKS >= 1");
  end

  state_t                 r_state, w_next;
  logic [BRICK_IDX_W-1:0] r_clear_index, w_index;
  logic [1:0]             r_lives;
  logic [5:0]             r_left;
  logic                   r_reload, r_serve;
  logic                   w_in_area, w_hit, w_new_game, w_auto_serve;

  brick_index_map u_map (
    .i_row     (i_ball_row),
    .i_col     (i_ball_col),
    .o_index   (w_index),
    .o_in_area (w_in_area)
  );

  assign w_hit      = w_in_area && bus.bricks[w_index];
  assign w_new_game = (r_state == IDLE) && i_start;

`ifdef BRICK_GAME_CTRL_AUTOSERVE_EN
  localparam int SCNT_W = $clog2(SERVE_TICKS + 1);
  logic [SCNT_W-1:0] r_serve_cnt;

  // Holding the counter at zero outside SERVE clears it on every entry.
  always_ff @(posedge i_clock) begin
    if (i_reset || r_state != SERVE) r_serve_cnt <= '0;
    else if (i_step_tick)            r_serve_cnt <= r_serve_cnt + 1'b1;
  end

  assign w_auto_serve = i_step_tick && (r_serve_cnt == SCNT_W'(SERVE_TICKS - 1));
`else
  assign w_auto_serve = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_ball_run      = 1'b0;
    bus.clear_valid = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_next = SERVE;
      SERVE: if (i_start || w_auto_serve) w_next = PLAY;
      PLAY: begin
        o_ball_run = 1'b1;
        // A miss outranks a hit seen on the same step.
        if (i_step_tick) begin
          if (i_ball_miss) w_next = MISS;
          else if (w_hit)  w_next = CLEAR;
        end
      end
      CLEAR: begin
        bus.clear_valid = 1'b1;
        if (bus.clear_ready) w_next = (r_left == 6'd1) ? WIN : PLAY;
      end
      MISS:      w_next = (r_lives == 2'd1) ? OVER : SERVE;
      WIN, OVER: if (i_start) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lives       <= LIVES_INIT;
      r_left        <= BRICKS_INIT;
      r_clear_index <= '0;
      r_reload      <= 1'b0;
      r_serve       <= 1'b0;
    end else begin
      r_reload <= w_new_game;
      r_serve  <= w_new_game || ((r_state == MISS) && (r_lives != 2'd1));
      if (w_new_game) begin
        r_lives <= LIVES_INIT;
        r_left  <= BRICKS_INIT;
      end
      if (r_state == PLAY && i_step_tick && !i_ball_miss && w_hit)
        r_clear_index <= w_index;
      if (r_state == CLEAR && bus.clear_ready && r_left != 6'd0)
        r_left <= r_left - 6'd1;
      if (r_state == MISS && r_lives != 2'd0)
        r_lives <= r_lives - 2'd1;
    end
  end

  assign bus.clear_index = r_clear_index;
  assign bus.reload      = r_reload;
  assign o_serve         = r_serve;
  assign o_lives         = r_lives;
  assign o_bricks_left   = r_left;
  assign o_state         = r_state;

endmodule
